// File: rtl/mem_lsu.sv
// -----------------------------------------------------------------------------
// mem_lsu -- load/store unit in front of a single-port, word-wide memory.
//
// Accepts one byte/half/word load or store at a time and completes it with a
// single-cycle response pulse. Sub-word stores are done as read-modify-write:
// the addressed word is read, the lane replaced, and the whole word written
// back one cycle later. Misaligned, illegal-size and out-of-range requests are
// rejected without touching memory.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_req_*               request: valid, we (1=store), size (00 b/01 h/10 w),
//                         unsigned (load zero-extend), byte addr, store data
//   o_req_ready           high only while idle
//   o_rsp_valid           one-cycle completion pulse
//   o_rsp_rdata           extended load data (0 for stores/faults/idle)
//   o_rsp_fault           request rejected
//   o_mem_address         word index (byte address >> 2) during an access
//   o_mem_data_write      word to write
//   o_mem_write_en        word write strobe
//   i_mem_data            combinational read data for o_mem_address
// -----------------------------------------------------------------------------
package mem_lsu_pkg;
    localparam int MEM_SIZE = 1024;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        MERGE_WR = 2'd2,
        RESP     = 2'd3
    } state_t;
endpackage

module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int MEM_WORDS = MEM_SIZE
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_fault,
    output addr_t       o_mem_address,
    output data_t       o_mem_data_write,
    output logic        o_mem_write_en,
    input  data_t       i_mem_data
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    state_t      state_q, state_d;

    // Latched request.
    logic        req_we_q;
    logic [1:0]  req_size_q;
    logic        req_uns_q;
    logic [31:0] req_addr_q;
    logic [31:0] req_wdata_q;
    logic        fault_q;

    logic [31:0] rdata_q;   // extended load result, held until RESP
    logic [31:0] merge_q;   // merged word for the sub-word store write-back

    logic        req_fault;
    logic [31:0] load_ext;
    logic [31:0] merged_word;
    logic        write_en_raw;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Fault decision is made on the incoming request so a rejected request can
    // skip straight to RESP.
    always_comb begin
        req_fault = 1'b0;
        if (i_req_size == SZ_BAD)                                req_fault = 1'b1;
        if (i_req_size == SZ_HALF && i_req_addr[0])              req_fault = 1'b1;
        if (i_req_size == SZ_WORD && i_req_addr[1:0] != 2'b00)   req_fault = 1'b1;
        if ({2'b00, i_req_addr[31:2]} >= 32'(MEM_WORDS))         req_fault = 1'b1;
    end

    // Lane extraction / merge, little-endian, from the word currently read.
    // NOTE: every signal assigned in an always_comb gets a default at the top so
    // no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        byte_lane   = i_mem_data[8 * req_addr_q[1:0] +: 8];
        half_lane   = i_mem_data[16 * req_addr_q[1] +: 16];
        load_ext    = i_mem_data;
        merged_word = i_mem_data;

        case (req_size_q)
            SZ_BYTE: load_ext = req_uns_q ? {24'b0, byte_lane}
                                          : {{24{byte_lane[7]}}, byte_lane};
            SZ_HALF: load_ext = req_uns_q ? {16'b0, half_lane}
                                          : {{16{half_lane[15]}}, half_lane};
            default: load_ext = i_mem_data;
        endcase

        if (req_size_q == SZ_BYTE)
            merged_word[8 * req_addr_q[1:0] +: 8] = req_wdata_q[7:0];
        else
            merged_word[16 * req_addr_q[1] +: 16] = req_wdata_q[15:0];
    end

    // Next-state and memory-side outputs.
    always_comb begin
        state_d          = state_q;
        o_req_ready      = 1'b0;
        write_en_raw     = 1'b0;
        o_mem_data_write = '0;
        o_mem_address    = '0;

        case (state_q)
            IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid)
                    state_d = req_fault ? RESP : ACCESS;
            end
            ACCESS: begin
                o_mem_address = {2'b00, req_addr_q[31:2]};
                if (req_we_q && req_size_q == SZ_WORD) begin
                    write_en_raw     = 1'b1;
                    o_mem_data_write = req_wdata_q;
                    state_d          = RESP;
                end else if (req_we_q) begin
                    state_d = MERGE_WR;
                end else begin
                    state_d = RESP;
                end
            end
            MERGE_WR: begin
                o_mem_address    = {2'b00, req_addr_q[31:2]};
                write_en_raw     = 1'b1;
                o_mem_data_write = merge_q;
                state_d          = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The memory samples the strobe on the same edge that applies reset, so the
    // strobe is masked by reset to abort an in-flight write.
    assign o_mem_write_en = write_en_raw & ~i_rst;

    assign o_rsp_valid = (state_q == RESP);
    assign o_rsp_rdata = o_rsp_valid ? rdata_q : 32'h0;
    assign o_rsp_fault = o_rsp_valid & fault_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // NOTE: the datapath registers are reset too; they are few and it
            // keeps outputs and debug views deterministic after reset.
            state_q     <= IDLE;
            req_we_q    <= 1'b0;
            req_size_q  <= 2'b00;
            req_uns_q   <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            fault_q     <= 1'b0;
            rdata_q     <= '0;
            merge_q     <= '0;
        end else begin
            state_q <= state_d;

            if (state_q == IDLE && i_req_valid) begin
                req_we_q    <= i_req_we;
                req_size_q  <= i_req_size;
                req_uns_q   <= i_req_unsigned;
                req_addr_q  <= i_req_addr;
                req_wdata_q <= i_req_wdata;
                fault_q     <= req_fault;
                rdata_q     <= '0;   // stores and faults respond with zero
            end

            if (state_q == ACCESS) begin
                if (!req_we_q) rdata_q <= load_ext;
                else           merge_q <= merged_word;
            end
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// -----------------------------------------------------------------------------
// tb_mem_lsu -- directed bench for mem_lsu with a behavioural memory, a
// reference copy of memory, and response/write scoreboards.
// -----------------------------------------------------------------------------
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    localparam int WORDS = 16;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_req_we = 1'b0;
    logic [1:0]  i_req_size = 2'b00;
    logic        i_req_unsigned = 1'b0;
    logic [31:0] i_req_addr = '0;
    logic [31:0] i_req_wdata = '0;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_fault;
    addr_t       o_mem_address;
    data_t       o_mem_data_write;
    logic        o_mem_write_en;
    data_t       i_mem_data;

    mem_lsu #(.MEM_WORDS(WORDS)) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_req_valid      (i_req_valid),
        .o_req_ready      (o_req_ready),
        .i_req_we         (i_req_we),
        .i_req_size       (i_req_size),
        .i_req_unsigned   (i_req_unsigned),
        .i_req_addr       (i_req_addr),
        .i_req_wdata      (i_req_wdata),
        .o_rsp_valid      (o_rsp_valid),
        .o_rsp_rdata      (o_rsp_rdata),
        .o_rsp_fault      (o_rsp_fault),
        .o_mem_address    (o_mem_address),
        .o_mem_data_write (o_mem_data_write),
        .o_mem_write_en   (o_mem_write_en),
        .i_mem_data       (i_mem_data)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    // ---------------- attached memory ----------------
    function automatic logic [31:0] init_val(input int i);
        case (i)
            1:       return 32'h8877_66F5;
            2:       return 32'hAABB_CCDD;
            default: return 32'hC0DE_0000 + 32'(i);
        endcase
    endfunction

    logic [31:0] mem [WORDS];
    logic        mem_init = 1'b1;

    always @(posedge i_clk) begin
        if (mem_init) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= init_val(i);
        end else if (o_mem_write_en && o_mem_address < 32'(WORDS)) begin
            mem[o_mem_address[3:0]] <= o_mem_data_write;
        end
    end

    assign i_mem_data = (o_mem_address < 32'(WORDS)) ? mem[o_mem_address[3:0]] : 32'h0;

    // ---------------- reference model and scoreboards ----------------
    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          lat;
    } rsp_t;

    typedef struct {
        int          off;
        logic [31:0] idx;
        logic [31:0] data;
    } wr_t;

    rsp_t        rsp_q[$];
    wr_t         wr_q[$];
    logic [31:0] model_mem [WORDS];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] idx, w, sh, mask, nw, r;
        logic        f;
        rsp_t        e;
        wr_t         wx;
        idx = addr >> 2;
        f = (size == 2'b11) || (size == 2'b01 && addr[0] == 1'b1) ||
            (size == 2'b10 && addr[1:0] != 2'b00) || (idx >= 32'(WORDS));
        if (f) begin
            e = '{rdata: 32'h0, fault: 1'b1, lat: 1};
            rsp_q.push_back(e);
            return;
        end
        w = model_mem[idx[3:0]];
        if (!we) begin
            if (size == 2'b00) begin
                sh = w >> {addr[1:0], 3'b000};
                r  = uns ? (sh & 32'hFF) : {{24{sh[7]}}, sh[7:0]};
            end else if (size == 2'b01) begin
                sh = w >> {addr[1], 4'b0000};
                r  = uns ? (sh & 32'hFFFF) : {{16{sh[15]}}, sh[15:0]};
            end else begin
                r = w;
            end
            e = '{rdata: r, fault: 1'b0, lat: 2};
            rsp_q.push_back(e);
        end else begin
            if (size == 2'b10) begin
                nw = wdata;
                wx = '{off: 1, idx: idx, data: nw};
                e  = '{rdata: 32'h0, fault: 1'b0, lat: 2};
            end else begin
                if (size == 2'b00) begin
                    mask = 32'hFF << {addr[1:0], 3'b000};
                    nw   = (w & ~mask) | ((wdata & 32'hFF) << {addr[1:0], 3'b000});
                end else begin
                    mask = 32'hFFFF << {addr[1], 4'b0000};
                    nw   = (w & ~mask) | ((wdata & 32'hFFFF) << {addr[1], 4'b0000});
                end
                wx = '{off: 2, idx: idx, data: nw};
                e  = '{rdata: 32'h0, fault: 1'b0, lat: 3};
            end
            model_mem[idx[3:0]] = nw;
            wr_q.push_back(wx);
            rsp_q.push_back(e);
        end
    endtask

    // Wait for ready, issue one request, then follow it to its response.
    // acc is the cycle count during the accept cycle.
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output int acc);
        rsp_t e;
        wr_t  wx;
        bit   got;
        int   guard;
        guard = 0;
        do begin
            @(negedge i_clk);
            guard++;
        end while (!o_req_ready && guard < 10);
        check("ready_before_req", 32'(o_req_ready), 32'd1);

        model(we, size, uns, addr, wdata);
        acc            = cyc;
        i_req_valid    = 1'b1;
        i_req_we       = we;
        i_req_size     = size;
        i_req_unsigned = uns;
        i_req_addr     = addr;
        i_req_wdata    = wdata;
        @(posedge i_clk);
        #1;
        i_req_valid = 1'b0;

        got = 0;
        for (int k = 0; k < 6 && !got; k++) begin
            @(negedge i_clk);
            if (o_mem_write_en) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_write", 32'(o_mem_write_en), 32'd0);
                end else begin
                    wx = wr_q.pop_front();
                    check("write_cycle", 32'(cyc - acc), 32'(wx.off));
                    check("write_index", o_mem_address, wx.idx);
                    check("write_data", o_mem_data_write, wx.data);
                end
            end
            if (o_rsp_valid) begin
                got = 1;
                e = rsp_q.pop_front();
                check("rsp_latency", 32'(cyc - acc), 32'(e.lat));
                check("rsp_rdata", o_rsp_rdata, e.rdata);
                check("rsp_fault", 32'(o_rsp_fault), 32'(e.fault));
                check("ready_low_in_resp", 32'(o_req_ready), 32'd0);
            end else begin
                check("idle_rdata_zero", o_rsp_rdata, 32'h0);
                check("idle_fault_zero", 32'(o_rsp_fault), 32'd0);
            end
        end
        if (!got) begin
            check("rsp_timeout", 32'(o_rsp_valid), 32'd1);
            rsp_q.delete();
        end
        check("missing_write", 32'(wr_q.size()), 32'd0);
        wr_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2;
        int guard;
        bit seen;

        for (int i = 0; i < WORDS; i++) model_mem[i] = init_val(i);

        // ---- reset ----
        i_rst    = 1'b1;
        mem_init = 1'b1;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_rst    = 1'b0;
        mem_init = 1'b0;
        check("reset_ready", 32'(o_req_ready), 32'd1);
        check("reset_rsp_valid", 32'(o_rsp_valid), 32'd0);
        check("reset_rdata", o_rsp_rdata, 32'h0);
        check("reset_fault", 32'(o_rsp_fault), 32'd0);
        check("reset_write_en", 32'(o_mem_write_en), 32'd0);
        check("reset_mem_address", o_mem_address, 32'h0);
        check("reset_mem_wdata", o_mem_data_write, 32'h0);

        // ---- byte loads, signed then unsigned, back-to-back ----
        do_req(1'b0, 2'b00, 1'b0, 32'h4, 32'h0, a1);
        do_req(1'b0, 2'b00, 1'b1, 32'h4, 32'h0, a2);
        check("b2b_load_spacing", 32'(a2 - a1), 32'd3);
        do_req(1'b0, 2'b00, 1'b1, 32'h7, 32'h0, a1);

        // ---- half store (RMW) and half loads ----
        do_req(1'b1, 2'b01, 1'b0, 32'hA, 32'hFFFF_1234, a1);
        do_req(1'b0, 2'b01, 1'b0, 32'hA, 32'h0, a1);
        do_req(1'b0, 2'b01, 1'b0, 32'h8, 32'h0, a1);
        do_req(1'b0, 2'b01, 1'b1, 32'h8, 32'h0, a1);

        // ---- word store then load of the same word ----
        do_req(1'b1, 2'b10, 1'b0, 32'hC, 32'hDEAD_BEEF, a1);
        do_req(1'b0, 2'b10, 1'b0, 32'hC, 32'h0, a2);
        check("store_then_load_spacing", 32'(a2 - a1), 32'd3);

        // ---- byte store into the top lane ----
        do_req(1'b1, 2'b00, 1'b0, 32'hF, 32'hFFFF_FFAB, a1);
        do_req(1'b0, 2'b10, 1'b0, 32'hC, 32'h0, a1);

        // ---- faults ----
        do_req(1'b0, 2'b01, 1'b0, 32'h3, 32'h0, a1);
        do_req(1'b0, 2'b10, 1'b0, 32'h2, 32'h0, a1);
        do_req(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, a1);
        do_req(1'b0, 2'b10, 1'b0, 32'(WORDS * 4), 32'h0, a1);
        do_req(1'b1, 2'b10, 1'b0, 32'(WORDS * 4), 32'h1111_2222, a1);
        do_req(1'b1, 2'b01, 1'b0, 32'h5, 32'h3333, a1);

        // ---- reset wins over a simultaneous request ----
        guard = 0;
        do begin @(negedge i_clk); guard++; end while (!o_req_ready && guard < 10);
        i_rst       = 1'b1;
        i_req_valid = 1'b1;
        i_req_we    = 1'b0;
        i_req_size  = 2'b10;
        i_req_addr  = 32'h4;
        @(posedge i_clk);
        #1;
        i_rst       = 1'b0;
        i_req_valid = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge i_clk);
            if (o_rsp_valid || o_mem_write_en) seen = 1;
        end
        check("rst_prio_no_activity", 32'(seen), 32'd0);
        check("rst_prio_ready", 32'(o_req_ready), 32'd1);

        // ---- reset during MERGE_WR of a byte store ----
        guard = 0;
        do begin @(negedge i_clk); guard++; end while (!o_req_ready && guard < 10);
        i_req_valid = 1'b1;
        i_req_we    = 1'b1;
        i_req_size  = 2'b00;
        i_req_addr  = 32'h5;
        i_req_wdata = 32'h99;
        @(posedge i_clk);
        #1;
        i_req_valid = 1'b0;
        @(negedge i_clk);   // ACCESS
        check("rmw_access_no_write", 32'(o_mem_write_en), 32'd0);
        @(negedge i_clk);   // MERGE_WR
        check("rmw_merge_addr", o_mem_address, 32'h1);
        i_rst = 1'b1;
        #1;
        check("rmw_rst_blocks_write", 32'(o_mem_write_en), 32'd0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        check("rmw_rst_ready", 32'(o_req_ready), 32'd1);
        check("rmw_rst_addr_zero", o_mem_address, 32'h0);
        check("rmw_mem_unchanged", mem[1], model_mem[1]);
        seen = 0;
        repeat (3) begin
            if (o_rsp_valid || o_mem_write_en) seen = 1;
            @(negedge i_clk);
        end
        check("rmw_rst_no_rsp", 32'(seen), 32'd0);

        // ---- normal operation after the abort ----
        do_req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, a1);

        // ---- final memory contents ----
        for (int i = 1; i < 4; i++) check($sformatf("final_mem_%0d", i), mem[i], model_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
